// File: rtl/nn_mac_layer.sv
// rtl/nn_mac_layer.sv - fully-connected neuron layer on one time-multiplexed MAC
//
// Purpose:
//   Computes NUM_OUT neuron outputs from NUM_IN signed inputs:
//     y_j = act( bias_j + sum_i f(x_i * w_ji >>> FRAC_BITS) )
//   with a single multiplier that steps through one input per cycle.
//   Weights and biases are written at run time through a config port.
//   f() either clamps (SAT_EN=1) or wraps (SAT_EN=0), and act() is an
//   optional ReLU. Overflow is reported as a sticky flag together with
//   the index of the first neuron that overflowed.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cfg_we/addr/wdata     weight/bias write; entry j*(NUM_IN+1)+i, i==NUM_IN is bias
//   in_valid/ready/data   input vector handshake, x_i at [i*DATA_W +: DATA_W]
//   out_valid/ready/data  result handshake, y_j at [j*DATA_W +: DATA_W]
//   ovf, ovf_neuron       sticky overflow flag and first overflowing neuron
//   zero                  every y_j of the last result is zero

module nn_mac_layer #(
    parameter int DATA_W    = 32,
    parameter int NUM_IN    = 2,
    parameter int NUM_OUT   = 2,
    parameter int FRAC_BITS = 0,
    parameter int SAT_EN    = 1,
    parameter int ACT_RELU  = 0,
    localparam int NUM_ENT  = NUM_OUT * (NUM_IN + 1),
    localparam int CFG_AW   = $clog2(NUM_ENT),
    localparam int NB_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [CFG_AW-1:0]         cfg_addr,
    input  logic [DATA_W-1:0]         cfg_wdata,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic                      ovf,
    output logic                      zero,
    output logic [NB_W-1:0]           ovf_neuron
);

    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    localparam logic signed [DATA_W-1:0] MAX_V     = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CFG_AW:0]          NUM_ENT_V = (CFG_AW+1)'(NUM_ENT);
    localparam logic [CFG_AW-1:0]        BIAS0_A   = CFG_AW'(NUM_IN);
    localparam logic [CFG_AW-1:0]        STRIDE    = CFG_AW'(NUM_IN + 1);
    localparam logic [IW-1:0]            I_LAST    = IW'(NUM_IN - 1);
    localparam logic [NB_W-1:0]          J_LAST    = NB_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ACT,
        S_DONE
    } state_t;

    state_t                      state_q;
    logic signed [DATA_W-1:0]    cfg_q [NUM_ENT];
    logic signed [DATA_W-1:0]    x_q [NUM_IN];
    logic signed [DATA_W-1:0]    acc_q;
    logic [CFG_AW-1:0]           ptr_q;
    logic [IW-1:0]               i_q;
    logic [NB_W-1:0]             j_q;
    // Working copy of finished neurons; out_data only changes when the
    // whole vector is ready, so an aborted transaction leaves no trace.
    logic signed [DATA_W-1:0]    y_q [NUM_OUT];
    logic [NUM_OUT*DATA_W-1:0]   out_data_q;
    logic                        out_valid_q;
    logic                        ovf_q;
    logic                        zero_q;
    logic [NB_W-1:0]             ovf_neuron_q;

    logic                        cfg_hit_d;
    logic signed [DATA_W-1:0]    x_cur_d;
    logic signed [DATA_W-1:0]    w_cur_d;
    logic signed [2*DATA_W-1:0]  prod_full_d;
    logic signed [2*DATA_W-1:0]  prod_sh_d;
    logic                        prod_ovf_d;
    logic signed [DATA_W-1:0]    prod_f_d;
    logic [DATA_W:0]             sum_full_d;
    logic                        sum_ovf_d;
    logic signed [DATA_W-1:0]    acc_d;
    logic                        mac_ovf_d;
    logic signed [DATA_W-1:0]    act_d;
    logic signed [DATA_W-1:0]    bias0_d;
    logic [CFG_AW-1:0]           bias_a_d;
    logic signed [DATA_W-1:0]    bias_nxt_d;
    logic                        zero_d;

    always_comb begin
        cfg_hit_d = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_addr} < NUM_ENT_V);

        // ptr_q walks the config table linearly: weights of neuron j,
        // then its bias slot, which ACT skips over to the next neuron.
        x_cur_d     = x_q[i_q];
        w_cur_d     = cfg_q[ptr_q];
        prod_full_d = x_cur_d * w_cur_d;
        prod_sh_d   = prod_full_d >>> FRAC_BITS;

        // In range only if the top DATA_W+1 bits are a pure sign extension.
        prod_ovf_d = !((&prod_sh_d[2*DATA_W-1:DATA_W-1]) ||
                       (~|prod_sh_d[2*DATA_W-1:DATA_W-1]));
        if (prod_ovf_d && (SAT_EN != 0)) begin
            prod_f_d = prod_sh_d[2*DATA_W-1] ? MIN_V : MAX_V;
        end else begin
            prod_f_d = prod_sh_d[DATA_W-1:0];
        end

        sum_full_d = {acc_q[DATA_W-1], acc_q} + {prod_f_d[DATA_W-1], prod_f_d};
        sum_ovf_d  = sum_full_d[DATA_W] ^ sum_full_d[DATA_W-1];
        if (sum_ovf_d && (SAT_EN != 0)) begin
            acc_d = sum_full_d[DATA_W] ? MIN_V : MAX_V;
        end else begin
            acc_d = sum_full_d[DATA_W-1:0];
        end
        mac_ovf_d = prod_ovf_d || sum_ovf_d;

        act_d = ((ACT_RELU != 0) && acc_q[DATA_W-1]) ? '0 : acc_q;

        // A bias write landing on the accept edge must be seen by neuron 0.
        bias0_d = (cfg_hit_d && (cfg_addr == BIAS0_A)) ? cfg_wdata : cfg_q[BIAS0_A];

        bias_a_d   = (j_q == J_LAST) ? BIAS0_A : ptr_q + STRIDE;
        bias_nxt_d = cfg_q[bias_a_d];

        zero_d = (act_d == '0);
        for (int k = 0; k < NUM_OUT - 1; k++) begin
            if (y_q[k] != '0) begin
                zero_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int k = 0; k < NUM_ENT; k++) begin
                cfg_q[k] <= '0;
            end
            for (int k = 0; k < NUM_IN; k++) begin
                x_q[k] <= '0;
            end
            for (int k = 0; k < NUM_OUT; k++) begin
                y_q[k] <= '0;
            end
            acc_q        <= '0;
            ptr_q        <= '0;
            i_q          <= '0;
            j_q          <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
            ovf_neuron_q <= '0;
        end else begin
            if (cfg_hit_d) begin
                cfg_q[cfg_addr] <= cfg_wdata;
            end

            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < NUM_IN; k++) begin
                            x_q[k] <= in_data[k*DATA_W +: DATA_W];
                        end
                        ovf_q        <= 1'b0;
                        ovf_neuron_q <= '0;
                        i_q          <= '0;
                        j_q          <= '0;
                        ptr_q        <= '0;
                        acc_q        <= bias0_d;
                        state_q      <= S_MAC;
                    end
                end

                S_MAC: begin
                    acc_q <= acc_d;
                    ptr_q <= ptr_q + 1'b1;
                    if (mac_ovf_d) begin
                        ovf_q <= 1'b1;
                        if (!ovf_q) begin
                            ovf_neuron_q <= j_q;
                        end
                    end
                    if (i_q == I_LAST) begin
                        state_q <= S_ACT;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end

                S_ACT: begin
                    y_q[j_q] <= act_d;
                    ptr_q    <= ptr_q + 1'b1;
                    if (j_q == J_LAST) begin
                        for (int k = 0; k < NUM_OUT; k++) begin
                            out_data_q[k*DATA_W +: DATA_W] <= (k == NUM_OUT - 1) ? act_d : y_q[k];
                        end
                        zero_q      <= zero_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        j_q     <= j_q + 1'b1;
                        i_q     <= '0;
                        acc_q   <= bias_nxt_d;
                        state_q <= S_MAC;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign ovf        = ovf_q;
    assign zero       = zero_q;
    assign ovf_neuron = ovf_neuron_q;

endmodule

// File: tb/tb_nn_mac_layer.sv
// tb/tb_nn_mac_layer.sv - self-checking bench for nn_mac_layer

`timescale 1ns/1ps

module tb_nn_mac_layer;

    // Four instances share stimulus: 0 saturating, 1 saturating+ReLU,
    // 2 wrapping, 3 saturating with FRAC_BITS=4.
    localparam bit [3:0] SAT_P  = 4'b1011;
    localparam bit [3:0] RELU_P = 4'b0010;
    localparam longint   MAXV   = 64'sd2147483647;
    localparam longint   MINV   = -64'sd2147483648;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        cfg_we    = 1'b0;
    logic [2:0]  cfg_addr  = '0;
    logic [31:0] cfg_wdata = '0;
    logic        in_valid  = 1'b0;
    logic [63:0] in_data   = '0;
    logic        out_ready = 1'b1;

    wire [63:0] od     [4];
    wire        ir     [4];
    wire        ov     [4];
    wire        ovf_w  [4];
    wire        zero_w [4];
    wire        ovn_w  [4];

    int checks = 0;
    int errors = 0;

    longint mcfg [6];
    longint mx   [2];
    longint my   [4][2];
    bit     movf [4];
    bit     mzero[4];
    int     movn [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        nn_mac_layer #(
            .DATA_W   (32),
            .NUM_IN   (2),
            .NUM_OUT  (2),
            .FRAC_BITS((g == 3) ? 4 : 0),
            .SAT_EN   (int'(SAT_P[g])),
            .ACT_RELU (int'(RELU_P[g]))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cfg_we    (cfg_we),
            .cfg_addr  (cfg_addr),
            .cfg_wdata (cfg_wdata),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_data   (in_data),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_data  (od[g]),
            .ovf       (ovf_w[g]),
            .zero      (zero_w[g]),
            .ovf_neuron(ovn_w[g])
        );
    end

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint fitv(input longint v, input bit sat, inout bit o);
        if (v > MAXV || v < MINV) begin
            o = 1'b1;
            if (sat) return (v > MAXV) ? MAXV : MINV;
            return longint'($signed(v[31:0]));
        end
        return v;
    endfunction

    // Reference layer evaluated with wide integer arithmetic.
    function automatic void model_all();
        bit     o;
        bit     seen;
        longint acc;
        longint p;
        for (int d = 0; d < 4; d++) begin
            o        = 1'b0;
            seen     = 1'b0;
            movn[d]  = 0;
            mzero[d] = 1'b1;
            for (int j = 0; j < 2; j++) begin
                acc = mcfg[j*3 + 2];
                for (int i = 0; i < 2; i++) begin
                    p   = (mx[i] * mcfg[j*3 + i]) >>> ((d == 3) ? 4 : 0);
                    p   = fitv(p, SAT_P[d], o);
                    acc = fitv(acc + p, SAT_P[d], o);
                    if (o && !seen) begin
                        seen    = 1'b1;
                        movn[d] = j;
                    end
                end
                if (RELU_P[d] && acc < 0) acc = 0;
                my[d][j] = acc;
                if (acc != 0) mzero[d] = 1'b0;
            end
            movf[d] = o;
        end
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 2))
            0:       return 32'($urandom_range(0, 200)) - 32'd100;
            1:       return 32'($urandom_range(0, 65535)) - 32'd32768;
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!ir[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic cfg_write(input int a, input logic [31:0] v);
        wait_idle();
        cfg_addr  = a[2:0];
        cfg_wdata = v;
        cfg_we    = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (a < 6) mcfg[a] = sx(v);
    endtask

    task automatic load_basic();
        cfg_write(0, 32'd2);
        cfg_write(1, 32'd3);
        cfg_write(2, 32'd1);
        cfg_write(3, 32'hFFFFFFFF);
        cfg_write(4, 32'd4);
        cfg_write(5, 32'hFFFFFFFB);
        cfg_write(6, 32'd77);
    endtask

    // Presents one vector, returns cycles from accept edge to out_valid.
    task automatic run_vec(input logic [31:0] x0, input logic [31:0] x1, output int lat);
        mx[0]    = sx(x0);
        mx[1]    = sx(x1);
        in_data  = {x1, x0};
        in_valid = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        model_all();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if ({ov[d], ovf_w[d], zero_w[d], ovn_w[d]} !== 4'b0 || od[d] !== 64'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got v=%b o=%b z=%b n=%b d=%h want all 0",
                         d, ov[d], ovf_w[d], zero_w[d], ovn_w[d], od[d]);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ir[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready dut%0d: got %b want 1", d, ir[d]);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        load_basic();
        run_vec(32'd10, 32'hFFFFFFFE, lat);
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 6", lat);
        end
        checks++;
        if (od[0] !== {32'hFFFFFFE9, 32'd15} || ovf_w[0] !== 1'b0 || zero_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_sat: got %h o=%b z=%b want ffffffe9_0000000f o=0 z=0",
                     od[0], ovf_w[0], zero_w[0]);
        end
        checks++;
        if (od[1] !== {32'd0, 32'd15} || zero_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL basic_relu: got %h z=%b want 00000000_0000000f z=0", od[1], zero_w[1]);
        end
        for (int d = 0; d < 4; d++) begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (od[d][j*32 +: 32] !== my[d][j][31:0]) begin
                    errors++;
                    $display("FAIL basic_model dut%0d y%0d: got %h want %h",
                             d, j, od[d][j*32 +: 32], my[d][j][31:0]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_vec(32'h7FFFFFFF, 32'h7FFFFFFF, lat);
        checks++;
        if (od[0] !== {32'hFFFFFFFF, 32'h7FFFFFFF} || ovf_w[0] !== 1'b1 || ovn_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sat: got %h o=%b n=%b want ffffffff_7fffffff o=1 n=0",
                     od[0], ovf_w[0], ovn_w[0]);
        end
        checks++;
        if (ovf_w[2] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap_flag: got %b want 1", ovf_w[2]);
        end
        for (int d = 0; d < 4; d++) begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (od[d][j*32 +: 32] !== my[d][j][31:0]) begin
                    errors++;
                    $display("FAIL ovf_model dut%0d y%0d: got %h want %h",
                             d, j, od[d][j*32 +: 32], my[d][j][31:0]);
                end
            end
            checks++;
            if ({ovf_w[d], zero_w[d], ovn_w[d]} !== {movf[d], mzero[d], movn[d][0]}) begin
                errors++;
                $display("FAIL ovf_flags dut%0d: got o=%b z=%b n=%b want o=%b z=%b n=%0d",
                         d, ovf_w[d], zero_w[d], ovn_w[d], movf[d], mzero[d], movn[d]);
            end
        end
    endtask

    task automatic test_zero();
        int lat;
        cfg_write(2, 32'd0);
        cfg_write(5, 32'd0);
        run_vec(32'd0, 32'd0, lat);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (od[d] !== 64'd0 || zero_w[d] !== 1'b1 || ovf_w[d] !== 1'b0) begin
                errors++;
                $display("FAIL zero_set dut%0d: got %h z=%b o=%b want 0 z=1 o=0",
                         d, od[d], zero_w[d], ovf_w[d]);
            end
        end
        run_vec(32'd1, 32'd0, lat);
        checks++;
        if (od[0][31:0] !== 32'd2 || zero_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_clear: got y0=%h z=%b want 00000002 z=0", od[0][31:0], zero_w[0]);
        end
        // Bias write on the very edge that accepts the vector.
        cfg_addr  = 3'd2;
        cfg_wdata = 32'd100;
        cfg_we    = 1'b1;
        mcfg[2]   = 100;
        run_vec(32'd1, 32'd0, lat);
        checks++;
        if (od[0][31:0] !== 32'd102) begin
            errors++;
            $display("FAIL cfg_on_accept: got y0=%h want 00000066", od[0][31:0]);
        end
    endtask

    task automatic test_hold();
        int lat;
        load_basic();
        out_ready = 1'b0;
        run_vec(32'd10, 32'hFFFFFFFE, lat);
        for (int k = 0; k < 5; k++) begin
            in_valid  = (k % 2 == 0);
            cfg_we    = 1'b1;
            cfg_addr  = 3'(k);
            cfg_wdata = $urandom;
            @(posedge clk); #1;
            checks++;
            if (od[0] !== {32'hFFFFFFE9, 32'd15} || ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %h v=%b r=%b want ffffffe9_0000000f v=1 r=0",
                         k, od[0], ov[0], ir[0]);
            end
        end
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got v=%b r=%b want v=0 r=1", ov[0], ir[0]);
        end
        run_vec(32'd10, 32'hFFFFFFFE, lat);
        checks++;
        if (od[0] !== {32'hFFFFFFE9, 32'd15}) begin
            errors++;
            $display("FAIL hold_weights: got %h want ffffffe9_0000000f", od[0]);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int t = 0;
        in_data  = {32'hFFFFFFFE, 32'd10};
        in_valid = 1'b1;
        while (!ov[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        do begin
            @(posedge clk); #1;
            t++;
        end while (ov[0] && t < 50);
        while (!ov[0] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        checks++;
        if (t != 8) begin
            errors++;
            $display("FAIL back_to_back_period: got %0d want 8", t);
        end
        checks++;
        if (od[0] !== {32'hFFFFFFE9, 32'd15}) begin
            errors++;
            $display("FAIL back_to_back_data: got %h want ffffffe9_0000000f", od[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        in_data  = {32'hFFFFFFFE, 32'd10};
        in_valid = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || od[d] !== 64'd0) begin
                errors++;
                $display("FAIL mid_reset dut%0d: got v=%b d=%h want v=0 d=0", d, ov[d], od[d]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) mcfg[k] = 0;
        @(posedge clk); #1;
        checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: got r=%b v=%b want r=1 v=0", ir[0], ov[0]);
        end
        run_vec(32'd10, 32'hFFFFFFFE, lat);
        checks++;
        if (od[0] !== 64'd0 || zero_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_weights: got %h z=%b want 0 z=1", od[0], zero_w[0]);
        end
        load_basic();
        run_vec(32'd10, 32'hFFFFFFFE, lat);
        checks++;
        if (od[0] !== {32'hFFFFFFE9, 32'd15} || lat != 6) begin
            errors++;
            $display("FAIL mid_reset_reload: got %h lat=%0d want ffffffe9_0000000f lat=6", od[0], lat);
        end
    endtask

    task automatic test_random();
        int lat;
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < 6; a++) cfg_write(a, rnd());
            cfg_write(6 + int'($urandom_range(0, 1)), rnd());
            run_vec(rnd(), rnd(), lat);
            checks++;
            if (lat != 6) begin
                errors++;
                $display("FAIL rand_latency it%0d: got %0d want 6", it, lat);
            end
            for (int d = 0; d < 4; d++) begin
                for (int j = 0; j < 2; j++) begin
                    checks++;
                    if (od[d][j*32 +: 32] !== my[d][j][31:0]) begin
                        errors++;
                        $display("FAIL rand_y it%0d dut%0d y%0d: got %h want %h",
                                 it, d, j, od[d][j*32 +: 32], my[d][j][31:0]);
                    end
                end
                checks++;
                if ({ovf_w[d], zero_w[d], ovn_w[d]} !== {movf[d], mzero[d], movn[d][0]}) begin
                    errors++;
                    $display("FAIL rand_flags it%0d dut%0d: got o=%b z=%b n=%b want o=%b z=%b n=%0d",
                             it, d, ovf_w[d], zero_w[d], ovn_w[d], movf[d], mzero[d], movn[d]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 6; k++) mcfg[k] = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_zero();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_mac_layer.md
Name: nn_mac_layer

Overview:
- Parametrised successor to the fixed 2-input `nn` datapath. It computes one fully-connected neuron layer with a single time-multiplexed MAC: NUM_OUT outputs from NUM_IN signed inputs.
- Weights and biases are loaded at run time through a config write port instead of a fixed ROM.
- Adds valid/ready handshakes on input and output, selectable saturating or wrapping arithmetic, optional ReLU, and first-overflow neuron reporting.
- Instances chain to form multi-layer networks.

Parameters:
- DATA_W, 32, signed width of inputs, weights, biases and outputs.
- NUM_IN, 2, inputs per neuron (>=1).
- NUM_OUT, 2, neurons in the layer (>=1).
- FRAC_BITS, 0, arithmetic right shift applied to each product (fixed-point scaling).
- SAT_EN, 1, 1 = clamp on overflow; 0 = two's-complement wrap.
- ACT_RELU, 0, 1 = negative neuron results forced to 0 after accumulation.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  weight/bias write strobe.
- cfg_addr  in  CFG_AW=$clog2(NUM_OUT*(NUM_IN+1))  entry index j*(NUM_IN+1)+i; i==NUM_IN is bias of neuron j.
- cfg_wdata  in  DATA_W  signed value to write.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  NUM_IN*DATA_W  x_i at bits [i*DATA_W +: DATA_W].
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  NUM_OUT*DATA_W  y_j at bits [j*DATA_W +: DATA_W].
- ovf  out  1  sticky: any overflow during the current/last transaction.
- zero  out  1  all y_j == 0 for the last result.
- ovf_neuron  out  max(1,$clog2(NUM_OUT))  index of first neuron that overflowed (0 if none).

Behaviour:
Reset:
- Async assert: state IDLE; weights, biases, out_data, ovf, zero, ovf_neuron, out_valid all 0.
- in_ready is 1 in IDLE once reset is low.
- Reset mid-transaction aborts it with no partial output.

Config writes:
- Applied on the clk edge when cfg_we=1, state==IDLE and cfg_addr < NUM_OUT*(NUM_IN+1).
- Otherwise the write is ignored (no error, no stall).
- A write coinciding with an input accept is applied; the new transaction uses the new value.

FSM IDLE -> MAC -> ACT -> DONE -> IDLE:
- IDLE: in_ready=1. On in_valid, latch in_data, clear ovf/ovf_neuron, set j=0, i=0, acc=bias_0, go MAC.
- MAC: one cycle per input, acc <= f(acc + f(x_i*w_ji >>> FRAC_BITS)). After i==NUM_IN-1 go ACT.
  - The product is formed at 2*DATA_W.
  - f = clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] when SAT_EN=1, else truncate to DATA_W.
  - A sum is formed at DATA_W+1 bits.
  - Any out-of-range product or sum sets ovf. If ovf was 0, ovf_neuron <= j.
- ACT: y_j <= (ACT_RELU && acc<0) ? 0 : acc.
  - If j<NUM_OUT-1: j++, i=0, acc=bias_{j+1}, go MAC.
  - Else: zero <= (all y==0), out_valid <= 1, go DONE.
- DONE: out_valid=1, in_ready=0, out_data/ovf/zero/ovf_neuron stable. On out_ready, go IDLE (out_valid drops next edge).

Latency and throughput:
- Input accepted at edge E0; out_valid rises at edge E0 + NUM_OUT*(NUM_IN+1). Default: 6 cycles.
- No overlap of transactions. Throughput is one vector per NUM_OUT*(NUM_IN+1)+2 cycles with out_ready held high.

Result holding:
- out_data and flags keep their last value after handshake until the next result is written.
- in_valid while not IDLE is ignored; the source must hold it.

Test Plan:
- Config w00=2, w01=3, b0=1, w10=-1, w11=4, b1=-5; in_data x=(10,-2), out_ready=1 -> out_valid exactly 6 cycles after accept; y0=15, y1=-23; ovf=0; zero=0.
- Same weights with ACT_RELU=1 -> y0=15, y1=0, zero=0.
- Same weights, x=(0x7FFFFFFF, 0x7FFFFFFF), SAT_EN=1 -> y0=0x7FFFFFFF, y1=-1 (0xFFFFFFFF); ovf=1, ovf_neuron=0. With SAT_EN=0, the results match a wrapped 32-bit reference model and ovf=1.
- All biases 0, x=(0,0) -> y=(0,0), zero=1, ovf=0. The next transaction with x=(1,0) clears zero (y0=2).
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and cfg_we -> out_data stable, in_ready=0, weights unchanged. Raise out_ready -> IDLE next cycle.
- Assert reset 3 cycles into MAC -> out_valid=0, out_data=0, weights=0, in_ready=1 after release. A reloaded config plus x=(10,-2) reproduces y=(15,-23).
